// File: rtl/pwm_duty_controller.sv
// pwm_duty_controller: debounces the increase/decrease buttons into one-shot duty steps and
// owns the saturating duty register (0..PERIOD) that feeds the PWM compare value.
module pwm_duty_controller #(
    parameter int unsigned PERIOD       = 10,
    parameter int unsigned STEP         = 1,
    parameter int unsigned DUTY_INIT    = 5,
    parameter int unsigned DEBOUNCE_CYC = 4,
    localparam int unsigned W           = $clog2(PERIOD + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_increase_duty,
    input  logic         i_decrease_duty,
    output logic [W-1:0] o_duty,
    output logic         o_duty_valid,
    output logic         o_at_max,
    output logic         o_at_min
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CntRelLast = CW'(DEBOUNCE_CYC - 1);
    localparam logic [W:0] PeriodExt = (W + 1)'(PERIOD);
    localparam logic [W:0] StepExt = (W + 1)'(STEP);

    typedef enum logic [1:0] {StIdle, StArmed, StApply, StWaitRel} state_e;

    logic [1:0]    r_sync_inc;
    logic [1:0]    r_sync_dec;
    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_dir_up;
    logic [W-1:0]  r_duty;
    logic          r_valid;

    state_e        w_state_d;
    logic [CW-1:0] w_cnt_d;
    logic          w_dir_up_d;
    logic [W-1:0]  w_duty_d;
    logic          w_valid_d;

    logic          w_inc_s;
    logic          w_dec_s;
    logic          w_single;
    logic          w_same;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_inc_val;
    logic [W-1:0]  w_dec_val;
    logic [W-1:0]  w_new_duty;

    // Two-flop synchronizers for the raw, asynchronous button levels.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync_inc <= 2'b00;
            r_sync_dec <= 2'b00;
        end else begin
            r_sync_inc <= {r_sync_inc[0], i_increase_duty};
            r_sync_dec <= {r_sync_dec[0], i_decrease_duty};
        end
    end

    assign w_inc_s  = r_sync_inc[1];
    assign w_dec_s  = r_sync_dec[1];
    assign w_single = w_inc_s ^ w_dec_s;
    assign w_same   = r_dir_up ? (w_inc_s & ~w_dec_s) : (w_dec_s & ~w_inc_s);

    // Saturating step arithmetic, widened by one bit so the increment cannot wrap.
    always_comb begin
        w_sum     = {1'b0, r_duty} + StepExt;
        w_inc_val = (w_sum > PeriodExt) ? PeriodExt[W-1:0] : w_sum[W-1:0];
        w_dec_val = ({1'b0, r_duty} < StepExt) ? '0 : (r_duty - StepExt[W-1:0]);
        w_new_duty = r_dir_up ? w_inc_val : w_dec_val;
    end

    // State, debounce counter, direction, duty and change pulse registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= StWaitRel;
            r_cnt    <= '0;
            r_dir_up <= 1'b0;
            r_duty   <= W'(DUTY_INIT);
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_dir_up <= w_dir_up_d;
            r_duty   <= w_duty_d;
            r_valid  <= w_valid_d;
        end
    end

    // Debounce FSM: arm on a single clean press, apply once, then demand a stable release.
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_dir_up_d = r_dir_up;
        w_duty_d   = r_duty;
        w_valid_d  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_single) begin
                    w_state_d  = StArmed;
                    w_dir_up_d = w_inc_s;
                    w_cnt_d    = CW'(1);
                end
            end
            StArmed: begin
                if (w_same) begin
                    if (r_cnt == CntMax) begin
                        w_state_d = StApply;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end else begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            end
            StApply: begin
                w_duty_d  = w_new_duty;
                // A saturated press that leaves duty unchanged is not reported.
                w_valid_d = (w_new_duty != r_duty);
                w_state_d = StWaitRel;
                w_cnt_d   = '0;
            end
            StWaitRel: begin
                if (w_inc_s || w_dec_s) begin
                    w_cnt_d = '0;
                end else if (r_cnt == CntRelLast) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_d = StWaitRel;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign o_duty       = r_duty;
    assign o_duty_valid = r_valid;
    assign o_at_max     = (r_duty == W'(PERIOD));
    assign o_at_min     = (r_duty == '0);

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Bench for pwm_duty_controller: directed scenarios plus random button traffic, all checked
// every cycle against a behavioural model of debounce, one-shot stepping and saturation.
module tb_pwm_duty_controller;

    localparam int PERIOD    = 10;
    localparam int STEP      = 1;
    localparam int DUTY_INIT = 5;
    localparam int D         = 4;
    localparam int W         = $clog2(PERIOD + 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inc;
    logic         dec;
    logic [W-1:0] duty;
    logic         duty_valid;
    logic         at_max;
    logic         at_min;

    pwm_duty_controller #(
        .PERIOD      (PERIOD),
        .STEP        (STEP),
        .DUTY_INIT   (DUTY_INIT),
        .DEBOUNCE_CYC(D)
    ) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_increase_duty(inc),
        .i_decrease_duty(dec),
        .o_duty         (duty),
        .o_duty_valid   (duty_valid),
        .o_at_max       (at_max),
        .o_at_min       (at_min)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses = 0;
    int last_valid_cyc = -1;
    int press_k = 0;
    bit en = 1'b0;

    // Model state: button samples delayed through the synchronizer, then debounce bookkeeping.
    logic [1:0] m_p1, m_p2;
    int  m_duty = DUTY_INIT;
    bit  m_valid = 1'b0;
    bit  m_ready = 1'b0;
    int  m_quiet = 0;
    int  m_len = 0;
    bit  m_up = 1'b0;
    bit  m_apply = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [1:0] s;
        int nd;
        if (!rst_n) begin
            m_duty = DUTY_INIT; m_valid = 0; m_p1 = 2'b00; m_p2 = 2'b00;
            m_ready = 0; m_quiet = 0; m_len = 0; m_apply = 0;
            return;
        end
        s = m_p2;
        m_p2 = m_p1;
        m_p1 = {inc, dec};
        m_valid = 0;
        if (m_apply) begin
            if (m_up) nd = (m_duty + STEP > PERIOD) ? PERIOD : m_duty + STEP;
            else      nd = (m_duty < STEP) ? 0 : m_duty - STEP;
            m_valid = (nd != m_duty);
            m_duty = nd;
            m_apply = 0; m_ready = 0; m_quiet = 0; m_len = 0;
        end else if (!m_ready) begin
            // Need D consecutive all-released samples before a new press is considered.
            if (s == 2'b00) begin
                m_quiet++;
                if (m_quiet == D) begin m_ready = 1; m_quiet = 0; end
            end else begin
                m_quiet = 0;
            end
        end else if (m_len == 0) begin
            if (s == 2'b10 || s == 2'b01) begin m_up = s[1]; m_len = 1; end
        end else if (s == (m_up ? 2'b10 : 2'b01)) begin
            if (m_len == D) begin m_apply = 1; m_len = 0; end
            else m_len++;
        end else begin
            m_len = 0;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (en) begin
            check("duty", int'(duty), m_duty);
            check("duty_valid", int'(duty_valid), int'(m_valid));
            check("at_max", int'(at_max), int'(m_duty == PERIOD));
            check("at_min", int'(at_min), int'(m_duty == 0));
            if (duty_valid === 1'b1) begin
                pulses++;
                last_valid_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic press(input bit up, input bit down, input int hold, input int gap);
        @(posedge clk); #2;
        inc = up; dec = down;
        press_k = cyc + 1;
        repeat (hold) @(posedge clk);
        #2; inc = 1'b0; dec = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    int p0;

    initial begin
        rst_n = 1'b0; inc = 1'b0; dec = 1'b0;
        @(posedge clk); #2;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Quiet after reset.
        idle(50);
        check("t1_duty", int'(duty), 5);
        check("t1_pulses", pulses, 0);
        check("t1_at_max", int'(at_max), 0);
        check("t1_at_min", int'(at_min), 0);

        // Three increments then three decrements, with latency of each pulse.
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            press(1'b1, 1'b0, 10, 10);
            check("t2_inc_latency", last_valid_cyc - press_k, D + 3);
            check("t2_inc_duty", int'(duty), 6 + i);
        end
        check("t2_inc_pulses", pulses - p0, 3);
        for (int i = 0; i < 3; i++) begin
            press(1'b0, 1'b1, 10, 10);
            check("t2_dec_latency", last_valid_cyc - press_k, D + 3);
        end
        check("t2_dec_duty", int'(duty), 5);
        check("t2_pulses", pulses - p0, 6);

        // Short glitch is rejected.
        p0 = pulses;
        press(1'b1, 1'b0, 2, 10);
        check("t3_duty", int'(duty), 5);
        check("t3_pulses", pulses - p0, 0);

        // Saturation at both ends.
        p0 = pulses;
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 10, 10);
        check("t4_max_duty", int'(duty), 10);
        check("t4_at_max", int'(at_max), 1);
        check("t4_max_pulses", pulses - p0, 5);
        p0 = pulses;
        for (int i = 0; i < 12; i++) press(1'b0, 1'b1, 10, 10);
        check("t4_min_duty", int'(duty), 0);
        check("t4_at_min", int'(at_min), 1);
        check("t4_min_pulses", pulses - p0, 10);

        // Both buttons together are ignored; a long hold yields exactly one step.
        p0 = pulses;
        press(1'b1, 1'b1, 20, 10);
        check("t5_both_duty", int'(duty), 0);
        check("t5_both_pulses", pulses - p0, 0);
        press(1'b1, 1'b0, 100, 10);
        check("t5_hold_duty", int'(duty), 1);
        check("t5_hold_pulses", pulses - p0, 1);

        // Reset while armed with the button still held.
        @(posedge clk); #2;
        inc = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        p0 = pulses;
        repeat (30) @(posedge clk);
        check("t6_held_duty", int'(duty), 5);
        check("t6_held_pulses", pulses - p0, 0);
        #2 inc = 1'b0;
        idle(10);
        press(1'b1, 1'b0, 10, 10);
        check("t6_repress_duty", int'(duty), 6);

        // Random button traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            int len;
            r = $urandom_range(0, 15);
            len = $urandom_range(1, 12);
            @(posedge clk); #2;
            if (r == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #2;
                rst_n = 1'b1;
            end else begin
                inc = r[0];
                dec = r[1];
                repeat (len) @(posedge clk);
            end
        end
        #2 inc = 1'b0; dec = 1'b0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
